// File: rtl/p3_pkg.sv
// Shared constants for the packet-buffer adapters: state encoding, default
// widths and the memory/stream word width derivation used by both adapters.
package p3_pkg;

  localparam int DEF_BYTE_ADDR_WIDTH = 12;
  localparam int DEF_ADDR_WIDTH      = 9;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] WRITE_ENC = 2'd1;
  localparam logic [1:0] DROP_ENC  = 2'd2;
  localparam logic [1:0] DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    WRITE = WRITE_ENC,
    DROP  = DROP_ENC,
    DONE  = DONE_ENC
  } snoop_state_t;

  // One buffer word holds 2**(byte bits - word bits) bytes.
  function automatic int data_width(input int byte_addr_w, input int addr_w);
    return (1 << (byte_addr_w - addr_w)) * 8;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational count of asserted TKEEP lanes.
module keep_popcount #(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_W      = $clog2(KEEP_WIDTH) + 1
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_W-1:0]      cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/snooper_adapter.sv
// Passive AXI-Stream tap that writes one packet into a granted buffer,
// counts its bytes and reports completion to the buffer manager.
module snooper_adapter
  import p3_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = DEF_BYTE_ADDR_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = data_width(BYTE_ADDR_WIDTH, ADDR_WIDTH),
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      sn_TDATA,
  input  logic [KEEP_WIDTH-1:0]      sn_TKEEP,
  input  logic                       sn_TLAST,
  input  logic                       sn_TVALID,
  output logic                       sn_TREADY,
  input  logic                       buf_rdy,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [BYTE_ADDR_WIDTH:0]   byte_length,
  output logic                       truncated,
  output logic                       done
);

  localparam int CNT_W = $clog2(KEEP_WIDTH) + 1;
  localparam logic [BYTE_ADDR_WIDTH:0] BYTE_MAX = (BYTE_ADDR_WIDTH+1)'(1) << BYTE_ADDR_WIDTH;

  function automatic logic [BYTE_ADDR_WIDTH:0] sat_bytes(
    input logic [BYTE_ADDR_WIDTH:0] acc,
    input logic [CNT_W-1:0]         add
  );
    logic [BYTE_ADDR_WIDTH+1:0] sum;
    sum = {1'b0, acc} + (BYTE_ADDR_WIDTH+2)'(add);
    if (sum > {1'b0, BYTE_MAX}) return BYTE_MAX;
    return sum[BYTE_ADDR_WIDTH:0];
  endfunction

  snoop_state_t               state, state_n;
  logic                       tready_q;
  logic                       in_pkt;
  logic [ADDR_WIDTH:0]        word_idx, word_idx_n;
  logic [BYTE_ADDR_WIDTH:0]   byte_cnt, byte_cnt_n;
  logic                       trunc_q, trunc_n;
  logic                       wr_en_p1, wr_en_n;
  logic [ADDR_WIDTH-1:0]      wr_addr_p1, wr_addr_n;
  logic [DATA_WIDTH-1:0]      wr_data_p1, wr_data_n;
  logic [CNT_W-1:0]           keep_cnt;
  logic                       beat_p0;

  keep_popcount #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .CNT_W      (CNT_W)
  ) u_popcount (
    .keep (sn_TKEEP),
    .cnt  (keep_cnt)
  );

  assign beat_p0 = sn_TVALID & tready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q <= 1'b0;
      in_pkt   <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (beat_p0) in_pkt <= ~sn_TLAST;
    end
  end

  // Stage p0 -> p1: accepted beat decides the write and next state.
  always_comb begin
    state_n    = state;
    word_idx_n = word_idx;
    byte_cnt_n = byte_cnt;
    trunc_n    = trunc_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr_p1;
    wr_data_n  = wr_data_p1;
    unique case (state)
      IDLE: begin
        if (beat_p0 && !in_pkt) begin
          if (buf_rdy) begin
            wr_en_n    = 1'b1;
            wr_addr_n  = '0;
            wr_data_n  = sn_TDATA;
            word_idx_n = (ADDR_WIDTH+1)'(1);
            byte_cnt_n = (BYTE_ADDR_WIDTH+1)'(keep_cnt);
            state_n    = sn_TLAST ? DONE : WRITE;
          end else if (!sn_TLAST) begin
            state_n = DROP;
          end
        end
      end
      WRITE: begin
        if (beat_p0) begin
          if (word_idx[ADDR_WIDTH]) begin
            trunc_n    = 1'b1;
            byte_cnt_n = BYTE_MAX;
          end else begin
            wr_en_n    = 1'b1;
            wr_addr_n  = word_idx[ADDR_WIDTH-1:0];
            wr_data_n  = sn_TDATA;
            word_idx_n = word_idx + 1'b1;
            byte_cnt_n = sat_bytes(byte_cnt, keep_cnt);
          end
          if (sn_TLAST) state_n = DONE;
        end
      end
      DROP: begin
        if (beat_p0 && sn_TLAST) state_n = IDLE;
      end
      DONE: begin
        // Hold the result until the manager withdraws the grant.
        if (!buf_rdy) begin
          state_n    = IDLE;
          word_idx_n = '0;
          byte_cnt_n = '0;
          trunc_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      byte_cnt   <= '0;
      trunc_q    <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      state      <= state_n;
      word_idx   <= word_idx_n;
      byte_cnt   <= byte_cnt_n;
      trunc_q    <= trunc_n;
      wr_en_p1   <= wr_en_n;
      wr_addr_p1 <= wr_addr_n;
      wr_data_p1 <= wr_data_n;
    end
  end

  // Stage p1: registered memory write and status outputs.
  assign sn_TREADY   = tready_q;
  assign wr_en       = wr_en_p1;
  assign wr_addr     = wr_addr_p1;
  assign wr_data     = wr_data_p1;
  assign byte_length = byte_cnt;
  assign truncated   = trunc_q;
  assign done        = (state == DONE);

endmodule

// File: tb/tb_snooper_adapter.sv
// Directed bench for snooper_adapter: writes, drops, overflow, handshake, reset.
module tb_snooper_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sn_TDATA = '0;
  logic [7:0]  sn_TKEEP = '0;
  logic        sn_TLAST = 1'b0;
  logic        sn_TVALID = 1'b0;
  logic        sn_TREADY;
  logic        buf_rdy = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic [12:0] byte_length;
  logic        truncated;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [8:0]  wa[$];
  logic [63:0] wd[$];

  always #5 clk = ~clk;

  snooper_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .sn_TDATA    (sn_TDATA),
    .sn_TKEEP    (sn_TKEEP),
    .sn_TLAST    (sn_TLAST),
    .sn_TVALID   (sn_TVALID),
    .sn_TREADY   (sn_TREADY),
    .buf_rdy     (buf_rdy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .byte_length (byte_length),
    .truncated   (truncated),
    .done        (done)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    @(negedge clk);
    sn_TDATA  = d;
    sn_TKEEP  = k;
    sn_TLAST  = l;
    sn_TVALID = 1'b1;
  endtask

  // Idle one cycle; on return outputs of the previous beat are settled.
  task automatic gap();
    @(negedge clk);
    sn_TVALID = 1'b0;
    sn_TLAST  = 1'b0;
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tready", 64'(sn_TREADY), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_len", 64'(byte_length), 64'd0);
    check("rst_trunc", 64'(truncated), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("tready_up", 64'(sn_TREADY), 64'd1);

    // 1: three-beat packet
    buf_rdy = 1'b1;
    clear_log();
    send(64'h0706050403020100, 8'hFF, 1'b0);
    send(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
    send(64'h1716151413121110, 8'h0F, 1'b1);
    gap();
    check("t1_done", 64'(done), 64'd1);
    check("t1_last_wr_coincident", 64'(wr_en), 64'd1);
    check("t1_len", 64'(byte_length), 64'd20);
    check("t1_trunc", 64'(truncated), 64'd0);
    check("t1_nwr", 64'(wa.size()), 64'd3);
    check("t1_a0", 64'(wa.size() > 0 ? wa[0] : 9'h1FF), 64'd0);
    check("t1_a2", 64'(wa.size() > 2 ? wa[2] : 9'h1FF), 64'd2);
    check("t1_d1", wd.size() > 1 ? wd[1] : 64'hX, 64'h0F0E0D0C0B0A0908);
    check("t1_d2", wd.size() > 2 ? wd[2] : 64'hX, 64'h1716151413121110);
    buf_rdy = 1'b0;
    gap();
    check("t1_done_fall", 64'(done), 64'd0);
    check("t1_wr_idle", 64'(wr_en), 64'd0);
    check("t1_len_clr", 64'(byte_length), 64'd0);

    // 2: packet starting without a buffer is dropped whole
    clear_log();
    send(64'hAAAA, 8'hFF, 1'b0);
    gap();
    buf_rdy = 1'b1;
    send(64'hBBBB, 8'hFF, 1'b1);
    gap();
    check("t2_drop_nwr", 64'(wa.size()), 64'd0);
    check("t2_drop_done", 64'(done), 64'd0);
    send(64'h1111, 8'hFF, 1'b0);
    send(64'h2222, 8'h03, 1'b1);
    gap();
    check("t2_nwr", 64'(wa.size()), 64'd2);
    check("t2_a0", 64'(wa.size() > 0 ? wa[0] : 9'h1FF), 64'd0);
    check("t2_d0", wd.size() > 0 ? wd[0] : 64'hX, 64'h1111);
    check("t2_len", 64'(byte_length), 64'd10);
    buf_rdy = 1'b0;
    gap();

    // 4: grant held after done; further packets ignored
    buf_rdy = 1'b1;
    clear_log();
    send(64'h00CCBBAA, 8'h07, 1'b1);
    gap();
    check("t4_done", 64'(done), 64'd1);
    check("t4_len", 64'(byte_length), 64'd3);
    for (int p = 0; p < 2; p++) begin
      send(64'hDEAD, 8'hFF, 1'b0);
      send(64'hBEEF, 8'hFF, 1'b1);
    end
    gap();
    check("t4_hold_nwr", 64'(wa.size()), 64'd1);
    check("t4_hold_done", 64'(done), 64'd1);
    check("t4_hold_len", 64'(byte_length), 64'd3);
    buf_rdy = 1'b0;
    gap();
    check("t4_released", 64'(done), 64'd0);
    buf_rdy = 1'b1;
    clear_log();
    send(64'hE0, 8'hFF, 1'b0);
    send(64'hE1, 8'hFF, 1'b1);
    gap();
    check("t4_nwr", 64'(wa.size()), 64'd2);
    check("t4_a1", 64'(wa.size() > 1 ? wa[1] : 9'h1FF), 64'd1);
    check("t4_d1", wd.size() > 1 ? wd[1] : 64'hX, 64'hE1);
    check("t4_len2", 64'(byte_length), 64'd16);
    buf_rdy = 1'b0;
    gap();

    // 5: zero-length single beat
    buf_rdy = 1'b1;
    clear_log();
    send(64'h5555, 8'h00, 1'b1);
    gap();
    check("t5_nwr", 64'(wa.size()), 64'd1);
    check("t5_a0", 64'(wa.size() > 0 ? wa[0] : 9'h1FF), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_len", 64'(byte_length), 64'd0);
    buf_rdy = 1'b0;
    gap();

    // 3: oversize packet truncated at 512 words
    buf_rdy = 1'b1;
    clear_log();
    for (int i = 0; i < 515; i++) send(64'(i), 8'hFF, i == 514);
    gap();
    check("t3_nwr", 64'(wa.size()), 64'd512);
    check("t3_alast", 64'(wa.size() > 511 ? wa[511] : 9'h0), 64'd511);
    check("t3_dlast", wd.size() > 511 ? wd[511] : 64'hX, 64'd511);
    check("t3_len", 64'(byte_length), 64'd4096);
    check("t3_trunc", 64'(truncated), 64'd1);
    check("t3_done", 64'(done), 64'd1);
    buf_rdy = 1'b0;
    gap();
    check("t3_trunc_clr", 64'(truncated), 64'd0);

    // 6: reset in the middle of a packet
    buf_rdy = 1'b1;
    clear_log();
    send(64'h61, 8'hFF, 1'b0);
    send(64'h62, 8'hFF, 1'b0);
    gap();
    check("t6_pre_wr", 64'(wr_en), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", 64'(wr_en), 64'd0);
    check("t6_rst_addr", 64'(wr_addr), 64'd0);
    check("t6_rst_data", wr_data, 64'd0);
    check("t6_rst_len", 64'(byte_length), 64'd0);
    check("t6_rst_tready", 64'(sn_TREADY), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    send(64'hF0, 8'hFF, 1'b1);
    gap();
    check("t6_nwr", 64'(wa.size()), 64'd1);
    check("t6_a0", 64'(wa.size() > 0 ? wa[0] : 9'h1FF), 64'd0);
    check("t6_d0", wd.size() > 0 ? wd[0] : 64'hX, 64'hF0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_len", 64'(byte_length), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
